fp_nan_dispatch: RTL and testbench
==================================

Name: fp_nan_dispatch

Overview:
- Front-end controller for a two-operand FP datapath (add/mul/min class).
- Accepts an operand pair and classifies each operand in turn, time-sharing one NaN classifier.
- NaN operands bypass the datapath and return a quieted NaN directly; all other pairs are issued to the datapath and its result is forwarded.
- Maintains the IEEE invalid (NV) flag, per result and sticky.

Parameters:
- SIGN_W, 1, sign field width
- EXPO_W, 8, exponent field width
- MANT_W, 23, mantissa field width
- FP_W, SIGN_W+EXPO_W+MANT_W, localparam, packed operand width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept a pair
- in_a  in  FP_W  operand A {sign,expo,mant}
- in_b  in  FP_W  operand B
- dp_valid  out  1  issue request to datapath
- dp_ready  in  1  datapath accepts issue
- dp_a  out  FP_W  registered operand A to datapath
- dp_b  out  FP_W  registered operand B to datapath
- dp_res_valid  in  1  single-cycle pulse, datapath result valid (no backpressure)
- dp_res  in  FP_W  datapath result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  FP_W  result
- out_nv  out  1  invalid flag for this result
- nv_sticky  out  1  accumulated invalid flag
- nv_clr  in  1  clear nv_sticky

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All state registered on clk.
- Reset values: state IDLE, in_ready=1, dp_valid=0, out_valid=0, out_nv=0, nv_sticky=0. dp_a, dp_b and out_res reset to 0.
- FSM states: IDLE, CHK_A, CHK_B, ISSUE, WAIT_DP, OUT.
- IDLE:
  - in_ready=1 only in IDLE.
  - On in_valid&in_ready, register in_a/in_b and go to CHK_A.
- CHK_A: shared classifier muxed to operand A. Register nan_a and snan_a. Go to CHK_B.
- CHK_B: classifier muxed to operand B. Register nan_b and snan_b.
  - If nan_a|nan_b: load out_res per NaN rule, out_nv=snan_a|snan_b, go to OUT.
  - Otherwise go to ISSUE.
- NaN classification:
  - NaN: expo all ones and mant≠0.
  - sNaN: NaN with mant[MANT_W-1]=0.
- NaN rule:
  - If nan_a, out_res = A with mant[MANT_W-1] forced to 1.
  - Otherwise out_res = B quieted the same way.
  - Sign and payload are preserved.
- ISSUE:
  - dp_valid=1; dp_a and dp_b hold stable until dp_ready.
  - On dp_valid&dp_ready go to WAIT_DP; dp_valid drops the next cycle.
- WAIT_DP:
  - On dp_res_valid: out_res=dp_res, out_nv=0, go to OUT.
  - Datapath latency is ≥1 cycle after the issue handshake.
- OUT:
  - out_valid=1; out_res and out_nv hold stable until out_ready.
  - On out_valid&out_ready go to IDLE.
  - The next pair is accepted no earlier than the cycle after the handshake.
- Latency:
  - NaN path: out_valid asserts 3 cycles after the in handshake.
  - Non-NaN path: issue 3 cycles after the in handshake; out_valid 1 cycle after dp_res_valid.
- One transaction in flight; in-order by construction.
- Infinities and zeros are not NaN and are always dispatched. Invalid cases such as inf-inf are the datapath's responsibility; this block reports out_nv=0 for them.
- dp_res_valid in any state other than WAIT_DP is ignored.
- nv_sticky:
  - Set on out handshake with out_nv=1.
  - nv_clr clears it.
  - Clear and set in the same cycle: set wins.
- rst mid-operation: transaction dropped, all outputs return to reset values next cycle. A late dp_res_valid after reset is ignored.

Optional Feature:
- Macro: FP_NAN_DISPATCH_DEFAULT_NAN_EN.
- When defined, the NaN path emits the canonical qNaN instead of the propagated NaN: sign=0, expo all ones, mant MSB=1, rest 0. out_nv behaviour is unchanged.
- When undefined, the payload-propagating rule above applies.

Decomposition:
- Shared package fp_nan_pkg:
  - state enum for the FSM
  - field-width parameters
  - function canon_qnan(EXPO_W, MANT_W)
  - function quiet(nan) that sets the mantissa MSB
- Sub-module: one instance of the existing nan_chk classifier (SIGN_W/EXPO_W/MANT_W passed through), input-muxed between the registered A and B. No other sub-modules.

Test Plan:
- a=0x3F800000, b=0x40000000 → dp_valid with the same values. Return dp_res=0x40400000 2 cycles after the issue handshake → out_res=0x40400000, out_nv=0, exactly one dp handshake.
- a=0x7F800001 (sNaN), b=0x3F800000 → no dp_valid. out_valid 3 cycles after accept with out_res=0x7FC00001, out_nv=1; nv_sticky=1 after the out handshake.
- a=0x3F800000, b=0xFFC00123 → out_res=0xFFC00123, out_nv=0. With FP_NAN_DISPATCH_DEFAULT_NAN_EN defined → 0x7FC00000.
- a=0x7F800000, b=0xFF800000 → both non-NaN, dispatched unchanged; out_nv=0.
- Backpressure: dp_ready low 4 cycles then high → dp_a/dp_b stable throughout. out_ready low 5 cycles → out_res stable and in_ready=0 until the out handshake.
- rst during WAIT_DP, then dp_res_valid pulse → no out_valid, state IDLE. Separately, nv_clr asserted in the same cycle as an sNaN out handshake → nv_sticky=1.

Source files
------------

// File: rtl/fp_nan_pkg.sv
// Shared types, default field widths and NaN helpers for the FP NaN dispatch front-end.
// Helpers work on a 64-bit container so any format up to double precision fits.
package fp_nan_pkg;

    localparam int SIGN_W_DEF = 1;
    localparam int EXPO_W_DEF = 8;
    localparam int MANT_W_DEF = 23;
    localparam int FP_MAX_W   = 64;

    typedef enum logic [2:0] {
        IDLE,
        CHK_A,
        CHK_B,
        ISSUE,
        WAIT_DP,
        OUT
    } state_t;

    // Canonical quiet NaN: positive sign, exponent all ones, only the mantissa MSB set.
    function automatic logic [FP_MAX_W-1:0] canon_qnan(input int expo_w, input int mant_w);
        logic [FP_MAX_W-1:0] expo_ones;
        expo_ones = (FP_MAX_W'(1) << expo_w) - FP_MAX_W'(1);
        return (expo_ones << mant_w) | (FP_MAX_W'(1) << (mant_w - 1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] quiet(input logic [FP_MAX_W-1:0] nan, input int mant_w);
        return nan | (FP_MAX_W'(1) << (mant_w - 1));
    endfunction

endpackage

// File: rtl/nan_chk.sv
// Combinational NaN / signalling-NaN classifier for one packed {sign,expo,mant} operand.
module nan_chk
    import fp_nan_pkg::*;
#(
    parameter int SIGN_W = SIGN_W_DEF,
    parameter int EXPO_W = EXPO_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] val,
    output logic                            is_nan,
    output logic                            is_snan
);

    logic [EXPO_W-1:0] expo;
    logic [MANT_W-1:0] mant;
    logic              unused_sign;

    assign expo        = val[MANT_W +: EXPO_W];
    assign mant        = val[MANT_W-1:0];
    assign unused_sign = ^val[SIGN_W+EXPO_W+MANT_W-1 -: SIGN_W];

    assign is_nan  = (&expo) && (|mant);
    assign is_snan = is_nan && !mant[MANT_W-1];

endmodule

// File: rtl/fp_nan_dispatch.sv
// Front-end for a two-operand FP datapath: NaN pairs are answered locally, others are issued.
// Define FP_NAN_DISPATCH_DEFAULT_NAN_EN to return the canonical qNaN instead of a propagated one.
module fp_nan_dispatch
    import fp_nan_pkg::*;
#(
    parameter  int SIGN_W = SIGN_W_DEF,
    parameter  int EXPO_W = EXPO_W_DEF,
    parameter  int MANT_W = MANT_W_DEF,
    localparam int FP_W   = SIGN_W + EXPO_W + MANT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    output logic            dp_valid,
    input  logic            dp_ready,
    output logic [FP_W-1:0] dp_a,
    output logic [FP_W-1:0] dp_b,
    input  logic            dp_res_valid,
    input  logic [FP_W-1:0] dp_res,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_res,
    output logic            out_nv,
    output logic            nv_sticky,
    input  logic            nv_clr
);

    state_t          state, state_nxt;
    logic [FP_W-1:0] a_reg, b_reg;
    logic [FP_W-1:0] chk_in;
    logic [FP_W-1:0] nan_res;
    logic            nan_a, snan_a;
    logic            chk_nan, chk_snan;

    // One classifier serves both operands; B's flags are consumed in the cycle they are produced.
    assign chk_in = (state == CHK_B) ? b_reg : a_reg;

    nan_chk #(
        .SIGN_W (SIGN_W),
        .EXPO_W (EXPO_W),
        .MANT_W (MANT_W)
    ) u_nan_chk (
        .val     (chk_in),
        .is_nan  (chk_nan),
        .is_snan (chk_snan)
    );

`ifdef FP_NAN_DISPATCH_DEFAULT_NAN_EN
    assign nan_res = FP_W'(canon_qnan(EXPO_W, MANT_W));
`else
    assign nan_res = nan_a ? FP_W'(quiet(FP_MAX_W'(a_reg), MANT_W))
                           : FP_W'(quiet(FP_MAX_W'(b_reg), MANT_W));
`endif

    assign dp_a = a_reg;
    assign dp_b = b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        dp_valid  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CHK_A;
            end
            CHK_A:   state_nxt = CHK_B;
            CHK_B:   state_nxt = (nan_a || chk_nan) ? OUT : ISSUE;
            ISSUE: begin
                dp_valid = 1'b1;
                if (dp_ready) state_nxt = WAIT_DP;
            end
            WAIT_DP: if (dp_res_valid) state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, classification flags, result and sticky NV; a set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            nan_a     <= 1'b0;
            snan_a    <= 1'b0;
            out_res   <= '0;
            out_nv    <= 1'b0;
            nv_sticky <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_reg <= in_a;
                b_reg <= in_b;
            end
            if (state == CHK_A) begin
                nan_a  <= chk_nan;
                snan_a <= chk_snan;
            end
            if (state == CHK_B && (nan_a || chk_nan)) begin
                out_res <= nan_res;
                out_nv  <= snan_a || chk_snan;
            end
            if (state == WAIT_DP && dp_res_valid) begin
                out_res <= dp_res;
                out_nv  <= 1'b0;
            end
            if (out_valid && out_ready && out_nv) begin
                nv_sticky <= 1'b1;
            end else if (nv_clr) begin
                nv_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_nan_dispatch.sv
// Self-checking bench for fp_nan_dispatch: directed vector table, hand sequences, random pairs.
module tb_fp_nan_dispatch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        dp_valid;
    logic        dp_ready;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic        dp_res_valid;
    logic [31:0] dp_res;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_nv;
    logic        nv_sticky;
    logic        nv_clr;

    int tests;
    int fails;
    int dp_hs;
    bit sticky_model;

`ifdef FP_NAN_DISPATCH_DEFAULT_NAN_EN
    localparam bit DEF_NAN = 1'b1;
`else
    localparam bit DEF_NAN = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] dres;
        bit          nan_path;
        logic [31:0] res;
        bit          nv;
        int          dp_delay;
        int          dp_stall;
        int          out_stall;
    } vec_t;

    vec_t vecs[7];

    fp_nan_dispatch dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .dp_valid     (dp_valid),
        .dp_ready     (dp_ready),
        .dp_a         (dp_a),
        .dp_b         (dp_b),
        .dp_res_valid (dp_res_valid),
        .dp_res       (dp_res),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_nv       (out_nv),
        .nv_sticky    (nv_sticky),
        .nv_clr       (nv_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dp_valid && dp_ready) dp_hs <= dp_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: field arithmetic on single-precision numbers.
    function automatic vec_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] dres);
        vec_t        v;
        int unsigned ea, eb, ma, mb;
        bit          na, nb, sa, sb;
        ea = (a >> 23) % 256;
        eb = (b >> 23) % 256;
        ma = a % (1 << 23);
        mb = b % (1 << 23);
        na = (ea == 255) && (ma != 0);
        nb = (eb == 255) && (mb != 0);
        sa = na && (ma < (1 << 22));
        sb = nb && (mb < (1 << 22));
        v.a = a;
        v.b = b;
        v.dres = dres;
        v.nan_path = na || nb;
        v.nv = sa || sb;
        if (DEF_NAN && v.nan_path) v.res = 32'h7FC00000;
        else if (na)               v.res = a | 32'h00400000;
        else if (nb)               v.res = b | 32'h00400000;
        else                       v.res = dres;
        v.dp_delay = 2;
        v.dp_stall = 0;
        v.out_stall = 0;
        return v;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 5);
        case (k)
            0, 1:    r = {r[31], 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            2:       r = {r[31], 8'hFF, 23'd0};
            3:       r = {r[31], 31'd0};
            default: r = r;
        endcase
        return r;
    endfunction

    // Drives one full transaction from IDLE back to IDLE and checks every phase of it.
    task automatic applyStimulus(input vec_t v, input bit clr_at_hs);
        int hs_before;
        bit stable;
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        hs_before = dp_hs;
        in_valid = 1'b1;
        in_a = v.a;
        in_b = v.b;
        tick();
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        checkOutput("early_valid_k1", 32'({dp_valid, out_valid}), 32'd0);
        dp_res_valid = 1'b1;
        dp_res = $urandom;
        tick();
        dp_res_valid = 1'b0;
        checkOutput("early_valid_k2", 32'({dp_valid, out_valid}), 32'd0);
        tick();
        if (v.nan_path) begin
            checkOutput("nan_out_valid_lat3", 32'({dp_valid, out_valid}), 32'd1);
        end else begin
            checkOutput("issue_valid_lat3", 32'({dp_valid, out_valid}), 32'd2);
            checkOutput("dp_a", dp_a, v.a);
            checkOutput("dp_b", dp_b, v.b);
            stable = 1'b1;
            for (int i = 0; i < v.dp_stall; i++) begin
                tick();
                if (!dp_valid || dp_a !== v.a || dp_b !== v.b) stable = 1'b0;
            end
            if (v.dp_stall > 0) checkOutput("dp_stall_stable", 32'(stable), 32'd1);
            dp_ready = 1'b1;
            tick();
            dp_ready = 1'b0;
            checkOutput("dp_valid_drop", 32'(dp_valid), 32'd0);
            for (int i = 1; i < v.dp_delay; i++) tick();
            dp_res_valid = 1'b1;
            dp_res = v.dres;
            tick();
            dp_res_valid = 1'b0;
            dp_res = $urandom;
            checkOutput("out_valid_after_res", 32'(out_valid), 32'd1);
        end
        checkOutput("dp_handshakes", 32'(dp_hs - hs_before), v.nan_path ? 32'd0 : 32'd1);
        checkOutput("out_res", out_res, v.res);
        checkOutput("out_nv", 32'(out_nv), 32'(v.nv));
        stable = 1'b1;
        for (int i = 0; i < v.out_stall; i++) begin
            tick();
            if (!out_valid || out_res !== v.res || out_nv !== v.nv || in_ready) stable = 1'b0;
        end
        if (v.out_stall > 0) checkOutput("out_stall_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        nv_clr = clr_at_hs;
        tick();
        out_ready = 1'b0;
        nv_clr = 1'b0;
        if (v.nv)           sticky_model = 1'b1;
        else if (clr_at_hs) sticky_model = 1'b0;
        checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
        checkOutput("nv_sticky", 32'(nv_sticky), 32'(sticky_model));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        tests = 0;
        fails = 0;
        dp_hs = 0;
        sticky_model = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        dp_ready = 1'b0;
        dp_res_valid = 1'b0;
        dp_res = '0;
        out_ready = 1'b0;
        nv_clr = 1'b0;

        vecs[0] = '{a: 32'h3F800000, b: 32'h40000000, dres: 32'h40400000, nan_path: 1'b0,
                    res: 32'h40400000, nv: 1'b0, dp_delay: 2, dp_stall: 0, out_stall: 0};
        vecs[1] = '{a: 32'h7F800001, b: 32'h3F800000, dres: 32'h0, nan_path: 1'b1,
                    res: DEF_NAN ? 32'h7FC00000 : 32'h7FC00001, nv: 1'b1, dp_delay: 2, dp_stall: 0, out_stall: 0};
        vecs[2] = '{a: 32'h3F800000, b: 32'hFFC00123, dres: 32'h0, nan_path: 1'b1,
                    res: DEF_NAN ? 32'h7FC00000 : 32'hFFC00123, nv: 1'b0, dp_delay: 2, dp_stall: 0, out_stall: 0};
        vecs[3] = '{a: 32'h7F800000, b: 32'hFF800000, dres: 32'h7FC00000, nan_path: 1'b0,
                    res: 32'h7FC00000, nv: 1'b0, dp_delay: 1, dp_stall: 0, out_stall: 0};
        vecs[4] = '{a: 32'h40A00000, b: 32'hC0000000, dres: 32'hC1200000, nan_path: 1'b0,
                    res: 32'hC1200000, nv: 1'b0, dp_delay: 3, dp_stall: 4, out_stall: 5};
        vecs[5] = '{a: 32'h7FC00000, b: 32'h7F800005, dres: 32'h0, nan_path: 1'b1,
                    res: 32'h7FC00000, nv: 1'b1, dp_delay: 2, dp_stall: 0, out_stall: 2};
        vecs[6] = '{a: 32'hFF812345, b: 32'h00000000, dres: 32'h0, nan_path: 1'b1,
                    res: DEF_NAN ? 32'h7FC00000 : 32'hFFC12345, nv: 1'b1, dp_delay: 2, dp_stall: 0, out_stall: 0};

        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_valids", 32'({dp_valid, out_valid}), 32'd0);
        checkOutput("reset_out_nv", 32'(out_nv), 32'd0);
        checkOutput("reset_nv_sticky", 32'(nv_sticky), 32'd0);
        checkOutput("reset_dp_a", dp_a, 32'd0);
        checkOutput("reset_dp_b", dp_b, 32'd0);
        checkOutput("reset_out_res", out_res, 32'd0);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], 1'b0);

        // Reset while waiting on the datapath, then a stale result pulse.
        in_valid = 1'b1;
        in_a = 32'h3F800000;
        in_b = 32'h40000000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        dp_ready = 1'b1;
        tick();
        dp_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sticky_model = 1'b0;
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mid_valids", 32'({dp_valid, out_valid}), 32'd0);
        checkOutput("rst_mid_out_res", out_res, 32'd0);
        checkOutput("rst_mid_sticky", 32'(nv_sticky), 32'd0);
        dp_res_valid = 1'b1;
        dp_res = 32'h40400000;
        tick();
        dp_res_valid = 1'b0;
        tick();
        checkOutput("late_res_ignored_valid", 32'(out_valid), 32'd0);
        checkOutput("late_res_ignored_idle", 32'(in_ready), 32'd1);

        // Sticky set by an sNaN, then a lone clear, then clear racing a set.
        applyStimulus(vecs[1], 1'b0);
        nv_clr = 1'b1;
        tick();
        nv_clr = 1'b0;
        sticky_model = 1'b0;
        checkOutput("nv_clr_alone", 32'(nv_sticky), 32'd0);
        applyStimulus(vecs[1], 1'b1);

        for (int n = 0; n < 40; n++) begin
            v = ref_model(rand_operand(), rand_operand(), $urandom);
            v.dp_delay = $urandom_range(1, 4);
            v.dp_stall = $urandom_range(0, 3);
            v.out_stall = $urandom_range(0, 3);
            applyStimulus(v, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
